// File: rtl/quiz_round_engine_if.sv
// Player/display bundle of the arithmetic-quiz engine: answer controls in, question/score display out.
interface quiz_round_engine_if #(
  parameter int unsigned OP_W   = 4,
  parameter int unsigned ANS_W  = 8,
  parameter int unsigned ROUNDS = 10
);
  logic              start;
  logic [1:0]        mode;
  logic [ANS_W-1:0]  answer_in;
  logic              check;
  logic [OP_W-1:0]   operand_a;
  logic [OP_W-1:0]   operand_b;
  logic [1:0]        op_code;
  logic [3:0]        seconds_left;
  logic [7:0]        round_idx;
  logic [7:0]        score;
  logic [ROUNDS-1:0] lights;
  logic              correct_flag;
  logic              wrong_flag;
  logic              timeout_flag;
  logic              done;

  modport master (
    output start, mode, answer_in, check,
    input  operand_a, operand_b, op_code, seconds_left, round_idx, score, lights,
           correct_flag, wrong_flag, timeout_flag, done
  );

  modport slave (
    input  start, mode, answer_in, check,
    output operand_a, operand_b, op_code, seconds_left, round_idx, score, lights,
           correct_flag, wrong_flag, timeout_flag, done
  );
endinterface

// File: rtl/quiz_round_engine.sv
// Arithmetic-quiz engine: LFSR operands, timed question, grading on check press, score over ROUNDS.
module quiz_round_engine #(
  parameter int unsigned OP_W          = 4,
  parameter int unsigned ANS_W         = 8,
  parameter int unsigned ROUNDS        = 10,
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned TIME_LIMIT    = 9,
  parameter int unsigned FB_TICKS      = 25_000_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic              clk,
  input logic              reset,
  quiz_round_engine_if.slave bus
);

  localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned FB_W   = (FB_TICKS > 1) ? $clog2(FB_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [FB_W-1:0]   FB_MAX   = FB_W'(FB_TICKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_ASK, S_FEEDBACK, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              start_prev_q, check_prev_q;
  logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [3:0]        sec_q, sec_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [FB_W-1:0]   fb_q, fb_d;
  logic [7:0]        round_q, round_d, score_q, score_d;
  logic              cor_q, cor_d, wr_q, wr_d, to_q, to_d;
  logic              start_edge, check_edge;
  logic [OP_W-1:0]   gen_a, gen_b;
  logic [ANS_W-1:0]  exp_val;
  logic [ROUNDS-1:0] lights;

  assign start_edge = bus.start & ~start_prev_q;
  assign check_edge = bus.check & ~check_prev_q;

  always_comb begin
    exp_val = '0;
    case (op_q)
      2'b00: exp_val = ANS_W'(a_q) + ANS_W'(b_q);
      2'b01: exp_val = ANS_W'(a_q) - ANS_W'(b_q);
      2'b10: exp_val = ANS_W'(a_q) * ANS_W'(b_q);
      default: exp_val = (b_q == '0) ? '0 : ANS_W'(a_q / b_q);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sec_d    = sec_q;
    tick_d   = tick_q;
    fb_d     = fb_q;
    round_d  = round_q;
    score_d  = score_q;
    cor_d    = cor_q;
    wr_d     = wr_q;
    to_d     = to_q;
    gen_a    = lfsr_q[OP_W-1:0];
    gen_b    = lfsr_q[2*OP_W-1:OP_W];

    case (state_q)
      S_GEN: begin
        op_d = bus.mode;
        if (bus.mode == 2'b01 && gen_a < gen_b) begin
          a_d = gen_b;
          b_d = gen_a;
        end else begin
          a_d = gen_a;
          b_d = gen_b;
        end
        if (bus.mode == 2'b11 && gen_b == '0) b_d = OP_W'(1);
        sec_d   = 4'(TIME_LIMIT);
        tick_d  = '0;
        state_d = S_ASK;
      end
      S_ASK: begin
        if (check_edge) begin
          state_d = S_FEEDBACK;
          fb_d    = '0;
          round_d = round_q + 8'd1;
          if (bus.answer_in == exp_val) begin
            cor_d = 1'b1;
            if (score_q < 8'(ROUNDS)) score_d = score_q + 8'd1;
          end else begin
            wr_d = 1'b1;
          end
        end else if (sec_q == 4'd0) begin
          state_d = S_FEEDBACK;
          fb_d    = '0;
          round_d = round_q + 8'd1;
          to_d    = 1'b1;
        end else if (tick_q == TICK_MAX) begin
          tick_d = '0;
          sec_d  = sec_q - 4'd1;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_FEEDBACK: begin
        if (fb_q == FB_MAX) begin
          cor_d   = 1'b0;
          wr_d    = 1'b0;
          to_d    = 1'b0;
          state_d = (round_q == 8'(ROUNDS)) ? S_DONE : S_GEN;
        end else begin
          fb_d = fb_q + FB_W'(1);
        end
      end
      default: ;
    endcase

    // A start edge in any state begins a fresh game and overrides any grading decided above.
    if (start_edge) begin
      state_d = S_GEN;
      score_d = '0;
      round_d = '0;
      cor_d   = 1'b0;
      wr_d    = 1'b0;
      to_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      start_prev_q <= 1'b0;
      check_prev_q <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      sec_q        <= '0;
      tick_q       <= '0;
      fb_q         <= '0;
      round_q      <= '0;
      score_q      <= '0;
      cor_q        <= 1'b0;
      wr_q         <= 1'b0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      start_prev_q <= bus.start;
      check_prev_q <= bus.check;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      sec_q        <= sec_d;
      tick_q       <= tick_d;
      fb_q         <= fb_d;
      round_q      <= round_d;
      score_q      <= score_d;
      cor_q        <= cor_d;
      wr_q         <= wr_d;
      to_q         <= to_d;
    end
  end

  always_comb begin
    lights = '0;
    for (int unsigned i = 0; i < ROUNDS; i++) lights[i] = (score_q > 8'(i));
  end

  assign bus.operand_a    = a_q;
  assign bus.operand_b    = b_q;
  assign bus.op_code      = op_q;
  assign bus.seconds_left = sec_q;
  assign bus.round_idx    = round_q;
  assign bus.score        = score_q;
  assign bus.lights       = lights;
  assign bus.correct_flag = cor_q;
  assign bus.wrong_flag   = wr_q;
  assign bus.timeout_flag = to_q;
  assign bus.done         = (state_q == S_DONE);

endmodule
